// File: rtl/axis_upsizer.sv
// AXI-Stream width up-converter: packs RATIO narrow beats into one wide word,
// little-endian lane order, tlast closes a word early with tkeep marking filled lanes.
module axis_upsizer #(
  parameter int unsigned IN_WIDTH = 64,
  parameter int unsigned RATIO    = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [IN_WIDTH-1:0]           slave_tdata,
  input  logic                          slave_tvalid,
  output logic                          slave_tready,
  input  logic                          slave_tlast,
  output logic [IN_WIDTH*RATIO-1:0]     master_tdata,
  output logic [IN_WIDTH*RATIO/8-1:0]   master_tkeep,
  output logic                          master_tvalid,
  input  logic                          master_tready,
  output logic                          master_tlast
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned IN_BYTES  = IN_WIDTH / 8;
  localparam int unsigned KEEP_W    = OUT_WIDTH / 8;
  localparam int unsigned CNT_W     = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_tdata;
  logic [KEEP_W-1:0]    r_tkeep;
  logic                 r_tlast;
  logic                 r_tvalid;

  logic                 w_accept;
  logic                 w_done;
  logic [OUT_WIDTH-1:0] w_word;
  logic [KEEP_W-1:0]    w_keep;

  // Gated by reset so the source sees no acceptance while the block is held.
  assign slave_tready = areset && (!r_tvalid || master_tready);
  assign w_accept     = slave_tvalid && slave_tready;
  assign w_done       = w_accept && ((r_cnt == LAST_LANE) || slave_tlast);

  // Lanes at and above r_cnt are always zero in r_acc, so only the current lane is merged.
  always_comb begin
    w_word = r_acc;
    w_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i == 32'(r_cnt)) begin
        w_word[i*IN_WIDTH +: IN_WIDTH] = slave_tdata;
      end
      if (i <= 32'(r_cnt)) begin
        w_keep[i*IN_BYTES +: IN_BYTES] = '1;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_done) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_word;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_done) begin
        r_tdata  <= w_word;
        r_tkeep  <= w_keep;
        r_tlast  <= slave_tlast;
        r_tvalid <= 1'b1;
      end else if (master_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign master_tdata  = r_tdata;
  assign master_tkeep  = r_tkeep;
  assign master_tlast  = r_tlast;
  assign master_tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed and randomized checks for axis_upsizer at the default 2 x 64-bit configuration.
module tb_axis_upsizer;

  logic         aclk;
  logic         areset;
  logic [63:0]  slave_tdata;
  logic         slave_tvalid;
  logic         slave_tready;
  logic         slave_tlast;
  logic [127:0] master_tdata;
  logic [15:0]  master_tkeep;
  logic         master_tvalid;
  logic         master_tready;
  logic         master_tlast;

  axis_upsizer #(.IN_WIDTH(64), .RATIO(2)) u_dut (
    .aclk          (aclk),
    .areset        (areset),
    .slave_tdata   (slave_tdata),
    .slave_tvalid  (slave_tvalid),
    .slave_tready  (slave_tready),
    .slave_tlast   (slave_tlast),
    .master_tdata  (master_tdata),
    .master_tkeep  (master_tkeep),
    .master_tvalid (master_tvalid),
    .master_tready (master_tready),
    .master_tlast  (master_tlast)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    int           cyc;
  } word_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  word_t outq[$];
  beat_t expq[$];
  int    cyc_cnt = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  bit    rnd_done;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Output handshakes are captured on the falling edge, where all signals are settled.
  always @(negedge aclk) begin
    word_t w;
    cyc_cnt++;
    if (master_tvalid && master_tready) begin
      w.d = master_tdata;
      w.k = master_tkeep;
      w.l = master_tlast;
      w.cyc = cyc_cnt;
      outq.push_back(w);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, output int waits);
    logic acc;
    slave_tdata  = d;
    slave_tlast  = l;
    slave_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge aclk);
      acc = slave_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 200) begin
        check("send_timeout", 128'(waits), 128'd0);
        break;
      end
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic [127:0] d,
                            input logic [15:0] k, input logic l);
    if (outq.size() > idx) begin
      check({tag, "_data"}, outq[idx].d, d);
      check({tag, "_keep"}, 128'(outq[idx].k), 128'(k));
      check({tag, "_last"}, 128'(outq[idx].l), 128'(l));
    end else begin
      check({tag, "_missing"}, 128'(outq.size()), 128'(idx + 1));
    end
  endtask

  task automatic release_reset();
    wait_cycles(2);
    areset = 1'b1;
    outq.delete();
  endtask

  initial begin
    int waits;
    int total_waits;
    int bi;
    logic [63:0] a, b, c, d, e, p, q, x1, x2, x3, x4;
    logic lastflag;
    beat_t bt;

    areset        = 1'b1;
    slave_tdata   = '0;
    slave_tvalid  = 1'b0;
    slave_tlast   = 1'b0;
    master_tready = 1'b0;
    rnd_done      = 1'b0;

    #2 areset = 1'b0;
    #1;
    check("rst_tvalid", 128'(master_tvalid), 128'd0);
    check("rst_tdata", master_tdata, 128'd0);
    check("rst_tkeep", 128'(master_tkeep), 128'd0);
    check("rst_tlast", 128'(master_tlast), 128'd0);
    master_tready = 1'b1;
    #1;
    check("rst_sready", 128'(slave_tready), 128'd0);
    wait_cycles(2);
    areset = 1'b1;
    outq.delete();
    #1;
    check("post_rst_sready", 128'(slave_tready), 128'd1);

    // Four beats, one packet
    send_beat(64'h1111_1111_1111_1111, 1'b0, waits);
    send_beat(64'h2222_2222_2222_2222, 1'b0, waits);
    send_beat(64'h3333_3333_3333_3333, 1'b0, waits);
    send_beat(64'h4444_4444_4444_4444, 1'b1, waits);
    slave_tvalid = 1'b0;
    wait_cycles(3);
    check("t1_count", 128'(outq.size()), 128'd2);
    check_word("t1_w0", 0, 128'h2222_2222_2222_2222_1111_1111_1111_1111, 16'hFFFF, 1'b0);
    check_word("t1_w1", 1, 128'h4444_4444_4444_4444_3333_3333_3333_3333, 16'hFFFF, 1'b1);
    outq.delete();

    // Three-beat packet leaves lane 1 empty in the closing word
    a = 64'hAAAA_0001_0203_0405;
    b = 64'hBBBB_1011_1213_1415;
    c = 64'hCCCC_2021_2223_2425;
    send_beat(a, 1'b0, waits);
    send_beat(b, 1'b0, waits);
    send_beat(c, 1'b1, waits);
    slave_tvalid = 1'b0;
    wait_cycles(3);
    check("t2_count", 128'(outq.size()), 128'd2);
    check_word("t2_w0", 0, {b, a}, 16'hFFFF, 1'b0);
    check_word("t2_w1", 1, {64'h0, c}, 16'h00FF, 1'b1);
    outq.delete();

    // Backpressure: pending word must hold while the source keeps presenting
    x1 = 64'h0101_0101_0101_0101;
    x2 = 64'h0202_0202_0202_0202;
    x3 = 64'h0303_0303_0303_0303;
    x4 = 64'h0404_0404_0404_0404;
    master_tready = 1'b0;
    send_beat(x1, 1'b0, waits);
    send_beat(x2, 1'b0, waits);
    slave_tdata = x3;
    slave_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_sready", 128'(slave_tready), 128'd0);
      check("bp_tvalid", 128'(master_tvalid), 128'd1);
      check("bp_tdata", master_tdata, {x2, x1});
      check("bp_tkeep", 128'(master_tkeep), 128'hFFFF);
      check("bp_tlast", 128'(master_tlast), 128'd0);
      @(posedge aclk);
      #1;
    end
    master_tready = 1'b1;
    send_beat(x3, 1'b0, waits);
    check("bp_release_wait", 128'(waits), 128'd0);
    send_beat(x4, 1'b1, waits);
    slave_tvalid = 1'b0;
    wait_cycles(3);
    check("bp_count", 128'(outq.size()), 128'd2);
    check_word("bp_w0", 0, {x2, x1}, 16'hFFFF, 1'b0);
    check_word("bp_w1", 1, {x4, x3}, 16'hFFFF, 1'b1);
    outq.delete();

    // Streaming 20 beats at full rate
    total_waits = 0;
    for (int i = 0; i < 20; i++) begin
      send_beat({32'hC0DE_0000 + 32'(i), 32'(i * 7)}, (i == 19), waits);
      total_waits += waits;
    end
    slave_tvalid = 1'b0;
    wait_cycles(3);
    check("st_stalls", 128'(total_waits), 128'd0);
    check("st_count", 128'(outq.size()), 128'd10);
    for (int w = 0; w < 10; w++) begin
      if (w < outq.size()) begin
        check("st_data", outq[w].d,
              {32'hC0DE_0000 + 32'(2*w+1), 32'((2*w+1) * 7), 32'hC0DE_0000 + 32'(2*w), 32'((2*w) * 7)});
        check("st_last", 128'(outq[w].l), 128'(w == 9));
        if (w > 0) check("st_spacing", 128'(outq[w].cyc - outq[w-1].cyc), 128'd2);
      end
    end
    outq.delete();

    // Reset with a word pending, then reset with a partial word
    p = 64'h5050_5050_5050_5050;
    q = 64'h6060_6060_6060_6060;
    master_tready = 1'b0;
    send_beat(p, 1'b0, waits);
    send_beat(q, 1'b0, waits);
    slave_tvalid = 1'b0;
    check("mr_pending", 128'(master_tvalid), 128'd1);
    #1 areset = 1'b0;
    #1;
    check("mr_tvalid_drop", 128'(master_tvalid), 128'd0);
    check("mr_tdata_clr", master_tdata, 128'd0);
    check("mr_sready", 128'(slave_tready), 128'd0);
    @(posedge aclk);
    #1;
    release_reset();
    master_tready = 1'b1;
    a = 64'hDEAD_BEEF_0000_000A;
    d = 64'h0000_0000_0000_000D;
    e = 64'h0000_0000_0000_000E;
    send_beat(a, 1'b0, waits);
    slave_tvalid = 1'b0;
    #2 areset = 1'b0;
    #1;
    check("mr2_tvalid", 128'(master_tvalid), 128'd0);
    @(posedge aclk);
    #1;
    release_reset();
    send_beat(d, 1'b0, waits);
    send_beat(e, 1'b0, waits);
    slave_tvalid = 1'b0;
    wait_cycles(3);
    check("mr_count", 128'(outq.size()), 128'd1);
    check_word("mr_w0", 0, {e, d}, 16'hFFFF, 1'b0);
    outq.delete();
    expq.delete();

    // Random valid/ready with random packet boundaries
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          bt.d = {$urandom, $urandom};
          bt.l = (i == 999) || ($urandom_range(0, 3) == 0);
          expq.push_back(bt);
          if ($urandom_range(0, 2) == 0) begin
            slave_tvalid = 1'b0;
            wait_cycles(1);
          end
          send_beat(bt.d, bt.l, waits);
        end
        slave_tvalid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          master_tready = 1'($urandom_range(0, 1));
          wait_cycles(1);
        end
        master_tready = 1'b1;
      end
    join
    wait_cycles(5);

    bi = 0;
    foreach (outq[w]) begin
      for (int l = 0; l < 2; l++) begin
        if (outq[w].k[l*8]) begin
          lastflag = outq[w].l && ((l == 1) || !outq[w].k[8]);
          if (bi < expq.size()) begin
            check("rnd_data", 128'(outq[w].d[l*64 +: 64]), 128'(expq[bi].d));
            check("rnd_last", 128'(lastflag), 128'(expq[bi].l));
          end
          bi++;
        end
      end
    end
    check("rnd_beats", 128'(bi), 128'(expq.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- AXI-Stream width up-converter placed directly upstream of the 128-bit XOR stage.
- Packs RATIO narrow input beats (default 2 x 64-bit, from the MAC/parser side) into one OUT_WIDTH word.
- Preserves packet boundaries: tlast closes a word early and marks the unused lanes via tkeep.
- Registered output; sustains one input beat per cycle under no backpressure.

Parameters:
- IN_WIDTH, 64, input data width in bits; must be a multiple of 8.
- RATIO, 2, input beats per output word; must be >= 2.
- OUT_WIDTH (localparam), IN_WIDTH*RATIO, output data width (128 by default).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-low reset.
- slave_tdata  in  IN_WIDTH  input beat data.
- slave_tvalid  in  1  input beat valid.
- slave_tready  out  1  input beat accepted when tvalid && tready.
- slave_tlast  in  1  last beat of packet.
- master_tdata  out  OUT_WIDTH  packed word; feeds the XOR stage slave_tdata.
- master_tkeep  out  OUT_WIDTH/8  byte-valid mask; lane i bytes set when lane i is filled.
- master_tvalid  out  1  output word valid.
- master_tready  in  1  downstream ready.
- master_tlast  out  1  word contains the last beat of the packet.

Behaviour:
- Reset (areset low, asynchronous, any time):
  - master_tvalid=0, master_tlast=0, master_tdata=0, master_tkeep=0.
  - Lane counter=0, accumulator cleared.
  - slave_tready=0 while areset is low.
  - A partially assembled word is discarded; no output until new beats arrive after release.
- slave_tready = !master_tvalid || master_tready, registered-free combinational. It must not depend on slave_tvalid or slave_tlast.
- Lane order: the first beat of a word goes to lane 0 (bits IN_WIDTH-1:0); beat k goes to lane k (little-endian lane packing).
- Lane counter: 0..RATIO-1.
  - Increments on each accepted beat.
  - Returns to 0 when a word completes.
- Word completes on an accepted beat when counter==RATIO-1 or slave_tlast=1.
- On completion, the output register loads on the same edge:
  - master_tdata = accumulated lanes plus the current beat; unfilled lanes are 0.
  - master_tkeep = all-ones for lanes 0..counter, 0 above.
  - master_tlast = slave_tlast.
  - master_tvalid = 1.
- Latency: master_tvalid rises the cycle after the completing beat is accepted.
- Output holds stable while master_tvalid && !master_tready (AXI rule: no change of data, keep or last).
- master_tvalid clears after the handshake unless a new word completes on that same edge; in that case the new word loads and tvalid stays 1.
- Non-completing beats are accepted whenever slave_tready=1. They only write the accumulator.
- Single-beat packet (tlast on lane 0): word emitted with only lane 0 kept.
- tlast with counter==RATIO-1: full tkeep, master_tlast=1.
- No beat is dropped or duplicated. The total count of kept bytes out equals IN_WIDTH/8 times the number of beats in.
- No packet state beyond the lane counter. Back-to-back packets need no idle cycle.

Test Plan:
- Reset then 4 beats, tlast on beat 4, master_tready=1:
  - inputs 0x1111.., 0x2222.., 0x3333.., 0x4444..
  - required: 2 words, {0x2222..,0x1111..} with tlast=0, then {0x4444..,0x3333..} with tlast=1.
  - tkeep=0xFFFF on both words.
- 3-beat packet (A,B,C with tlast on C):
  - required: word 1 = {B,A}, tkeep 0xFFFF, tlast=0.
  - required: word 2 = {0,C}, tkeep 0x00FF, tlast=1.
- Backpressure:
  - stimulus: hold master_tready=0 for 5 cycles with a word pending; slave_tvalid=1 continuously.
  - required: slave_tready=0 and master_tdata/tkeep/tlast stable across all 5 cycles.
  - required: on release, the next word appears the following cycle; no beats are lost.
- Streaming 20 beats, tready=1 always:
  - required: slave_tready stays 1 throughout.
  - required: 10 words, one every 2 cycles after the first; tlast only on the last word.
- Reset mid-word:
  - stimulus: accept beat A (counter=1), then assert areset between clock edges.
  - required: master_tvalid drops immediately.
  - required: after release, beats D,E produce {E,D}; A never appears.
- Random valid/ready toggling over 1000 beats with random tlast:
  - required: the output stream unpacked by tkeep equals the input stream exactly.
  - required: tlast positions match the input tlast positions.
